// File: rtl/lsu_mem_pkg.sv
// Shared definitions for the load/store unit: widths, extension codes,
// FSM encoding and access-size helpers.
package lsu_mem_pkg;

    localparam int LSU_XLEN   = 64;
    localparam int LSU_MASK_W = LSU_XLEN / 8;

    localparam logic [3:0] LSU_EXT_NONE = 4'd0;
    localparam logic [3:0] LSU_EXT_LW   = 4'd1;
    localparam logic [3:0] LSU_EXT_LWU  = 4'd2;
    localparam logic [3:0] LSU_EXT_LD   = 4'd3;
    localparam logic [3:0] LSU_EXT_LH   = 4'd4;
    localparam logic [3:0] LSU_EXT_LHU  = 4'd5;
    localparam logic [3:0] LSU_EXT_LB   = 4'd6;
    localparam logic [3:0] LSU_EXT_LBU  = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // {legal, low-address-bit mask that must be zero}; ext 0 is not a usable load
    function automatic logic [3:0] load_amask(input logic [3:0] ext);
        logic [3:0] r;
        case (ext)
            LSU_EXT_LW, LSU_EXT_LWU: r = 4'b1_011;
            LSU_EXT_LD:              r = 4'b1_111;
            LSU_EXT_LH, LSU_EXT_LHU: r = 4'b1_001;
            LSU_EXT_LB, LSU_EXT_LBU: r = 4'b1_000;
            default:                 r = 4'b0_000;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_amask(input logic [LSU_MASK_W-1:0] wmask);
        logic [3:0] cnt;
        logic [3:0] r;
        cnt = 4'd0;
        for (int i = 0; i < LSU_MASK_W; i++) begin
            cnt = cnt + {3'd0, wmask[i]};
        end
        case (cnt)
            4'd1:    r = 4'b1_000;
            4'd2:    r = 4'b1_001;
            4'd4:    r = 4'b1_011;
            4'd8:    r = 4'b1_111;
            default: r = 4'b0_000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Data-memory port of the load/store unit: request channel plus response.
interface lsu_mem_if #(
    parameter int XLEN   = 64,
    parameter int MASK_W = XLEN / 8
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [XLEN-1:0]   mem_addr;
    logic              mem_wen;
    logic [XLEN-1:0]   mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed field of an aligned read doubleword and extends it
// according to the load extension code.
module lsu_load_align
    import lsu_mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      offset_i,
    input  logic [3:0]      ext_i,
    output logic [XLEN-1:0] data_o
);
    logic [XLEN-1:0] sh_s;

    assign sh_s = rdata_i >> {offset_i, 3'b000};

    // Truncate to the access size, then sign- or zero-extend
    always_comb begin
        data_o = '0;
        case (ext_i)
            LSU_EXT_LW:  data_o = {{(XLEN-32){sh_s[31]}}, sh_s[31:0]};
            LSU_EXT_LWU: data_o = {{(XLEN-32){1'b0}}, sh_s[31:0]};
            LSU_EXT_LD:  data_o = sh_s;
            LSU_EXT_LH:  data_o = {{(XLEN-16){sh_s[15]}}, sh_s[15:0]};
            LSU_EXT_LHU: data_o = {{(XLEN-16){1'b0}}, sh_s[15:0]};
            LSU_EXT_LB:  data_o = {{(XLEN-8){sh_s[7]}}, sh_s[7:0]};
            LSU_EXT_LBU: data_o = {{(XLEN-8){1'b0}}, sh_s[7:0]};
            default:     data_o = '0;
        endcase
    end
endmodule

// File: rtl/lsu_mem.sv
// Load/store unit: one memory operation in flight between execute and
// writeback, aligned 64-bit memory accesses, extended load results.
module lsu_mem
    import lsu_mem_pkg::*;
#(
    parameter int XLEN   = LSU_XLEN,
    parameter int MASK_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    input  logic [3:0]        req_ext,
    input  logic [4:0]        req_rd,
    lsu_mem_if.master         mem,
    output logic              resp_valid,
    output logic              resp_wen,
    output logic [4:0]        resp_rd,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);
    lsu_state_e        state_q, state_d;
    logic [2:0]        off_q;
    logic [3:0]        ext_q;
    logic [4:0]        rd_q;
    logic              store_q;
    logic [XLEN-1:0]   mem_addr_q, mem_wdata_q;
    logic [MASK_W-1:0] mem_wmask_q;
    logic              mem_wen_q;
    logic              resp_valid_q, resp_wen_q, resp_err_q;
    logic [4:0]        resp_rd_q;
    logic [XLEN-1:0]   resp_rdata_q;

    logic [3:0]        amask_s;
    logic              misalign_s, accept_s, capture_s, err_s;
    logic [XLEN-1:0]   align_s;

    // Store wins when both flags are set, so its size decides alignment
    assign amask_s    = req_store ? store_amask(req_wmask) : load_amask(req_ext);
    assign misalign_s = !amask_s[3] || (|(req_addr[2:0] & amask_s[2:0]));
    assign accept_s   = (state_q == ST_IDLE) && req_valid && (req_load || req_store);

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .rdata_i  (mem.mem_rdata),
        .offset_i (off_q),
        .ext_i    (ext_q),
        .data_o   (align_s)
    );

    // Next-state logic; capture_s marks the cycle the read data is taken
    always_comb begin
        state_d   = state_q;
        capture_s = 1'b0;
        err_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = misalign_s ? ST_RESP : ST_ISSUE;
                    err_s   = misalign_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem.mem_req_ready && mem.mem_resp_valid) begin
                    state_d   = ST_RESP;
                    capture_s = 1'b1;
                end else if (mem.mem_req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (mem.mem_resp_valid) begin
                    state_d   = ST_RESP;
                    capture_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, request latch and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            off_q        <= 3'd0;
            ext_q        <= 4'd0;
            rd_q         <= 5'd0;
            store_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            mem_wen_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_wen_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rd_q    <= 5'd0;
            resp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                off_q       <= req_addr[2:0];
                ext_q       <= req_ext;
                rd_q        <= req_rd;
                store_q     <= req_store;
                mem_addr_q  <= {req_addr[XLEN-1:3], 3'b000};
                mem_wen_q   <= req_store;
                mem_wdata_q <= req_store ? (req_wdata << {req_addr[2:0], 3'b000}) : '0;
                mem_wmask_q <= req_store ? (req_wmask << req_addr[2:0]) : '0;
            end
            if (state_d == ST_RESP) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= err_s;
                resp_wen_q   <= capture_s && !store_q && (rd_q != 5'd0);
                resp_rd_q    <= (capture_s && !store_q) ? rd_q : 5'd0;
                resp_rdata_q <= (capture_s && !store_q) ? align_s : '0;
            end else begin
                resp_valid_q <= 1'b0;
                resp_err_q   <= 1'b0;
                resp_wen_q   <= 1'b0;
                resp_rd_q    <= 5'd0;
                resp_rdata_q <= '0;
            end
        end
    end

    assign req_ready         = (state_q == ST_IDLE);
    assign mem.mem_req_valid = (state_q == ST_ISSUE);
    assign mem.mem_addr      = mem_addr_q;
    assign mem.mem_wen       = mem_wen_q;
    assign mem.mem_wdata     = mem_wdata_q;
    assign mem.mem_wmask     = mem_wmask_q;

    assign resp_valid = resp_valid_q;
    assign resp_wen   = resp_wen_q;
    assign resp_rd    = resp_rd_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_lsu_mem.sv
// Directed vector bench for lsu_mem with a zero-wait memory plus stall and
// reset corner sequences.
module tb_lsu_mem;
    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic [3:0]  req_ext;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_wen, resp_err;
    logic [4:0]  resp_rd;
    logic [63:0] resp_rdata;

    int total = 0;
    int bad   = 0;

    lsu_mem_if #(.XLEN(64), .MASK_W(8)) mif ();

    lsu_mem dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .req_ext    (req_ext),
        .req_rd     (req_rd),
        .mem        (mif),
        .resp_valid (resp_valid),
        .resp_wen   (resp_wen),
        .resp_rd    (resp_rd),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [3:0]  ext;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic        err;
        logic [63:0] e_maddr;
        logic        e_mwen;
        logic [63:0] e_mwdata;
        logic [7:0]  e_mwmask;
        logic        e_wen;
        logic [4:0]  e_rd;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [7:0] wmask,
                                input logic [3:0] ext, input logic [4:0] rd,
                                input logic [63:0] rdata, input logic err,
                                input logic [63:0] e_maddr, input logic e_mwen,
                                input logic [63:0] e_mwdata, input logic [7:0] e_mwmask,
                                input logic e_wen, input logic [4:0] e_rd,
                                input logic [63:0] e_rdata);
        vec_t v;
        v.ld = ld; v.st = st; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
        v.ext = ext; v.rd = rd; v.rdata = rdata; v.err = err;
        v.e_maddr = e_maddr; v.e_mwen = e_mwen; v.e_mwdata = e_mwdata;
        v.e_mwmask = e_mwmask; v.e_wen = e_wen; v.e_rd = e_rd; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic drive_req(input vec_t v);
        req_valid = 1'b1;
        req_load  = v.ld;
        req_store = v.st;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wmask = v.wmask;
        req_ext   = v.ext;
        req_rd    = v.rd;
    endtask

    // Called just after a negedge; zero-wait memory
    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        drive_req(v);
        mif.mem_rdata      = v.rdata;
        mif.mem_req_ready  = 1'b1;
        mif.mem_resp_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk({t, ".req_ready_busy"}, {63'd0, req_ready}, 64'd0);
        if (v.err) begin
            chk({t, ".no_mem_req"}, {63'd0, mif.mem_req_valid}, 64'd0);
            chk({t, ".err_valid"},  {63'd0, resp_valid}, 64'd1);
            chk({t, ".err_flag"},   {63'd0, resp_err}, 64'd1);
            chk({t, ".err_wen"},    {63'd0, resp_wen}, 64'd0);
            chk({t, ".err_rdata"},  resp_rdata, 64'd0);
        end else begin
            chk({t, ".mem_req_valid"}, {63'd0, mif.mem_req_valid}, 64'd1);
            chk({t, ".mem_addr"},      mif.mem_addr, v.e_maddr);
            chk({t, ".mem_wen"},       {63'd0, mif.mem_wen}, {63'd0, v.e_mwen});
            if (v.e_mwen) begin
                chk({t, ".mem_wdata"}, mif.mem_wdata, v.e_mwdata);
                chk({t, ".mem_wmask"}, {56'd0, mif.mem_wmask}, {56'd0, v.e_mwmask});
            end
            chk({t, ".resp_early"}, {63'd0, resp_valid}, 64'd0);
            @(negedge clk);
            chk({t, ".resp_valid"}, {63'd0, resp_valid}, 64'd1);
            chk({t, ".resp_err"},   {63'd0, resp_err}, 64'd0);
            chk({t, ".resp_wen"},   {63'd0, resp_wen}, {63'd0, v.e_wen});
            chk({t, ".resp_rd"},    {59'd0, resp_rd}, {59'd0, v.e_rd});
            chk({t, ".resp_rdata"}, resp_rdata, v.e_rdata);
        end
        @(negedge clk);
        chk({t, ".resp_drop"},  {63'd0, resp_valid}, 64'd0);
        chk({t, ".ready_back"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0; req_wmask = 8'd0; req_ext = 4'd0; req_rd = 5'd0;
        mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0; mif.mem_rdata = 64'd0;

        //            ld    st    addr                    wdata                   wmask  ext   rd     rdata                   err   maddr                   mwen  mwdata                  mwmask wen   rd     rdata
        vecs[0]  = mk(1'b1, 1'b0, 64'h0000_0000_8000_0004, 64'd0,                 8'h00, 4'd1, 5'd5,  64'h8765_4321_0000_0000, 1'b0, 64'h0000_0000_8000_0000, 1'b0, 64'd0,                 8'h00, 1'b1, 5'd5,  64'hFFFF_FFFF_8765_4321);
        vecs[1]  = mk(1'b0, 1'b1, 64'h0000_0000_0000_1003, 64'h0000_0000_0000_00AB, 8'h01, 4'd0, 5'd0,  64'd0,                 1'b0, 64'h0000_0000_0000_1000, 1'b1, 64'h0000_0000_AB00_0000, 8'h08, 1'b0, 5'd0,  64'd0);
        vecs[2]  = mk(1'b1, 1'b0, 64'h0000_0000_0000_1004, 64'd0,                 8'h00, 4'd3, 5'd7,  64'd0,                 1'b1, 64'd0,                 1'b0, 64'd0,                 8'h00, 1'b0, 5'd0,  64'd0);
        vecs[3]  = mk(1'b0, 1'b1, 64'h0000_0000_0000_1001, 64'h0000_0000_0000_1234, 8'h03, 4'd0, 5'd0,  64'd0,                 1'b1, 64'd0,                 1'b0, 64'd0,                 8'h00, 1'b0, 5'd0,  64'd0);
        vecs[4]  = mk(1'b1, 1'b0, 64'h0000_0000_0000_2007, 64'd0,                 8'h00, 4'd7, 5'd3,  64'h8000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_2000, 1'b0, 64'd0,                 8'h00, 1'b1, 5'd3,  64'h0000_0000_0000_0080);
        vecs[5]  = mk(1'b1, 1'b0, 64'h0000_0000_0000_2007, 64'd0,                 8'h00, 4'd6, 5'd3,  64'h8000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_2000, 1'b0, 64'd0,                 8'h00, 1'b1, 5'd3,  64'hFFFF_FFFF_FFFF_FF80);
        vecs[6]  = mk(1'b1, 1'b0, 64'h0000_0000_0000_2006, 64'd0,                 8'h00, 4'd5, 5'd9,  64'hBEEF_0000_0000_0000, 1'b0, 64'h0000_0000_0000_2000, 1'b0, 64'd0,                 8'h00, 1'b1, 5'd9,  64'h0000_0000_0000_BEEF);
        vecs[7]  = mk(1'b1, 1'b0, 64'h0000_0000_0000_2006, 64'd0,                 8'h00, 4'd4, 5'd9,  64'hBEEF_0000_0000_0000, 1'b0, 64'h0000_0000_0000_2000, 1'b0, 64'd0,                 8'h00, 1'b1, 5'd9,  64'hFFFF_FFFF_FFFF_BEEF);
        vecs[8]  = mk(1'b1, 1'b0, 64'h0000_0000_0000_3004, 64'd0,                 8'h00, 4'd2, 5'd31, 64'h8765_4321_0000_0000, 1'b0, 64'h0000_0000_0000_3000, 1'b0, 64'd0,                 8'h00, 1'b1, 5'd31, 64'h0000_0000_8765_4321);
        vecs[9]  = mk(1'b1, 1'b0, 64'h0000_0000_0000_3008, 64'd0,                 8'h00, 4'd3, 5'd1,  64'h0123_4567_89AB_CDEF, 1'b0, 64'h0000_0000_0000_3008, 1'b0, 64'd0,                 8'h00, 1'b1, 5'd1,  64'h0123_4567_89AB_CDEF);
        vecs[10] = mk(1'b1, 1'b0, 64'h0000_0000_0000_3000, 64'd0,                 8'h00, 4'd3, 5'd0,  64'h0000_0000_0000_0055, 1'b0, 64'h0000_0000_0000_3000, 1'b0, 64'd0,                 8'h00, 1'b0, 5'd0,  64'h0000_0000_0000_0055);
        vecs[11] = mk(1'b0, 1'b1, 64'h0000_0000_0000_4004, 64'h0000_0000_DEAD_BEEF, 8'h0F, 4'd0, 5'd0,  64'd0,                 1'b0, 64'h0000_0000_0000_4000, 1'b1, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b0, 5'd0,  64'd0);
        vecs[12] = mk(1'b0, 1'b1, 64'h0000_0000_0000_4000, 64'h1122_3344_5566_7788, 8'hFF, 4'd0, 5'd0,  64'd0,                 1'b0, 64'h0000_0000_0000_4000, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 5'd0,  64'd0);
        vecs[13] = mk(1'b1, 1'b0, 64'h0000_0000_0000_0000, 64'd0,                 8'h00, 4'd9, 5'd4,  64'd0,                 1'b1, 64'd0,                 1'b0, 64'd0,                 8'h00, 1'b0, 5'd0,  64'd0);
        vecs[14] = mk(1'b1, 1'b1, 64'h0000_0000_0000_5002, 64'h0000_0000_0000_1234, 8'h03, 4'd1, 5'd6,  64'd0,                 1'b0, 64'h0000_0000_0000_5000, 1'b1, 64'h0000_0000_1234_0000, 8'h0C, 1'b0, 5'd0,  64'd0);
        vecs[15] = mk(1'b0, 1'b1, 64'h0000_0000_0000_4002, 64'h0000_0000_DEAD_BEEF, 8'h0F, 4'd0, 5'd0,  64'd0,                 1'b1, 64'd0,                 1'b0, 64'd0,                 8'h00, 1'b0, 5'd0,  64'd0);

        @(negedge clk);
        chk("rst.req_ready",     {63'd0, req_ready}, 64'd1);
        chk("rst.mem_req_valid", {63'd0, mif.mem_req_valid}, 64'd0);
        chk("rst.mem_addr",      mif.mem_addr, 64'd0);
        chk("rst.resp_valid",    {63'd0, resp_valid}, 64'd0);
        chk("rst.resp_rdata",    resp_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_vec(i, vecs[i]);
        end

        // Neither load nor store: ignored
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b0; req_addr = 64'h1000;
        @(negedge clk);
        req_valid = 1'b0;
        chk("nop.req_ready", {63'd0, req_ready}, 64'd1);
        chk("nop.mem_req",   {63'd0, mif.mem_req_valid}, 64'd0);
        chk("nop.resp",      {63'd0, resp_valid}, 64'd0);

        // Memory back-pressure then delayed response
        mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0;
        drive_req(mk(1'b0, 1'b1, 64'h6000, 64'hCAFE_F00D_1234_5678, 8'hFF, 4'd0, 5'd0,
                     64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00, 1'b0, 5'd0, 64'd0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk("stall.mem_req_valid", {63'd0, mif.mem_req_valid}, 64'd1);
            chk("stall.mem_addr",      mif.mem_addr, 64'h6000);
            chk("stall.mem_wdata",     mif.mem_wdata, 64'hCAFE_F00D_1234_5678);
            chk("stall.mem_wmask",     {56'd0, mif.mem_wmask}, 64'h0000_0000_0000_00FF);
            chk("stall.req_ready",     {63'd0, req_ready}, 64'd0);
            chk("stall.resp_valid",    {63'd0, resp_valid}, 64'd0);
        end
        mif.mem_req_ready = 1'b1;
        @(negedge clk);
        mif.mem_req_ready = 1'b0;
        chk("wait1.mem_req_valid", {63'd0, mif.mem_req_valid}, 64'd0);
        chk("wait1.req_ready",     {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        chk("wait2.resp_valid",    {63'd0, resp_valid}, 64'd0);
        mif.mem_resp_valid = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mif.mem_resp_valid = 1'b0;
            if (resp_valid) begin
                pulses++;
                chk("stall.resp_wen", {63'd0, resp_wen}, 64'd0);
            end
        end
        chk("stall.pulses", 64'(pulses), 64'd1);
        chk("stall.ready_back", {63'd0, req_ready}, 64'd1);

        // Reset while waiting for the memory response
        mif.mem_req_ready = 1'b1; mif.mem_resp_valid = 1'b0;
        drive_req(vecs[0]);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        mif.mem_req_ready = 1'b0;
        chk("rwait.mem_req_valid", {63'd0, mif.mem_req_valid}, 64'd0);
        chk("rwait.req_ready",     {63'd0, req_ready}, 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("rmid.req_ready",  {63'd0, req_ready}, 64'd1);
        chk("rmid.mem_addr",   mif.mem_addr, 64'd0);
        chk("rmid.resp_valid", {63'd0, resp_valid}, 64'd0);
        mif.mem_resp_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rpost.resp_valid", {63'd0, resp_valid}, 64'd0);
            chk("rpost.req_ready",  {63'd0, req_ready}, 64'd1);
        end
        run_vec(100, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_mem.md
Name: lsu_mem

Overview:
- Load/store unit that executes the memory side of the decoder's control outputs (store flag, store byte mask, load extension code, destination register).
- Accepts one memory operation per handshake from the execute stage and issues an aligned 64-bit access to the data memory port.
- Returns sign/zero-extended load data with a register writeback request, or a completion for stores.
- Sits between execute and writeback; one operation in flight.

Parameters:
- XLEN, 64, data/address width
- MASK_W, 8, byte-mask width (XLEN/8)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  operation offered
- req_ready  out  1  unit can accept
- req_load  in  1  load operation
- req_store  in  1  store operation (decoder s_flag)
- req_addr  in  XLEN  effective byte address
- req_wdata  in  XLEN  store data, LSB-aligned
- req_wmask  in  MASK_W  store size mask, LSB-aligned (0x01/0x03/0x0F/0xFF)
- req_ext  in  4  load size/extension code
- req_rd  in  5  load destination register
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  request address, req_addr with [2:0] cleared
- mem_wen  out  1  write request
- mem_wdata  out  XLEN  req_wdata shifted left by 8*addr[2:0]
- mem_wmask  out  MASK_W  req_wmask shifted left by addr[2:0]
- mem_resp_valid  in  1  read data valid / write acknowledge
- mem_rdata  in  XLEN  aligned read doubleword
- resp_valid  out  1  one-cycle completion pulse
- resp_wen  out  1  register writeback enable
- resp_rd  out  5  writeback address
- resp_rdata  out  XLEN  extended load data
- resp_err  out  1  misaligned access, no memory traffic

Behaviour:
- Reset: all outputs 0, except req_ready=1. State IDLE. Reset mid-operation aborts the access; no response is produced.
- Extension codes:
  - 0: none
  - 1: LW, sign-extend
  - 2: LWU
  - 3: LD
  - 4: LH
  - 5: LHU
  - 6: LB
  - 7: LBU
  - 8-15: illegal, treated as misaligned (resp_err).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid with req_load or req_store, latch all req_* signals.
  - Aligned access → ISSUE. Misaligned access → RESP with err. Misaligned means address not a multiple of the access size; store size comes from the popcount of req_wmask.
  - req_valid with neither load nor store: ignored, stay IDLE.
  - req_load and req_store both set: store wins.
- ISSUE:
  - mem_req_valid=1, with mem_addr/wen/wdata/wmask stable until mem_req_ready.
  - On mem_req_ready → WAIT.
  - mem_req_ready and mem_resp_valid in the same cycle → RESP directly, capturing mem_rdata.
- WAIT: on mem_resp_valid, capture mem_rdata → RESP.
- RESP:
  - resp_valid=1 for exactly one cycle → IDLE.
  - Load: resp_wen=1 unless rd==0; resp_rd=rd.
  - resp_rdata = mem_rdata >> 8*addr[2:0], truncated to size, then sign- or zero-extended per code.
  - Store: resp_wen=0, resp_rdata=0.
  - Error: resp_err=1, resp_wen=0.
- req_ready=0 in ISSUE, WAIT and RESP. Minimum latency for an aligned access with a zero-wait memory: accept at N, mem_req_valid at N+1, resp_valid at N+2.
- resp_* outputs are registered; they hold 0 whenever resp_valid=0.
- mem_resp_valid outside WAIT/ISSUE: ignored.

Decomposition:
- Shared package/defines file:
  - extension-code constants (LSU_EXT_*)
  - FSM state encoding
  - MASK_W derivation
- Natural sub-module: lsu_load_align. Purely combinational; takes rdata, offset and ext code and returns extended data. Shared with any future cache path.

Test Plan:
- LW at 0x8000_0004, mem_rdata=0x8765_4321_0000_0000, ext=1, rd=5 → mem_addr=0x8000_0000, resp_rdata=0xFFFF_FFFF_8765_4321, resp_wen=1, resp_rd=5, resp_valid at N+2 with zero-wait memory.
- SB at 0x1003, wdata=0xAB, wmask=0x01 → mem_wen=1, mem_wmask=0x08, mem_wdata[31:24]=0xAB, resp_valid with resp_wen=0.
- LD at 0x1004 → no mem_req_valid, resp_valid with resp_err=1 one cycle after accept; same for SH at 0x1001.
- mem_req_ready held low 3 cycles, then mem_resp_valid 2 cycles later → addr/wdata/wmask stable throughout, req_ready=0, single resp_valid pulse.
- LBU at offset 7, byte 0x80 → resp_rdata=0x80. LB same access → 0xFFFF_FFFF_FFFF_FF80. LHU at offset 6 with 0xBEEF → 0xBEEF.
- rst asserted during WAIT → outputs 0 immediately, req_ready=1, no resp_valid; a following load completes normally.
